// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its lane aligner.
package dmem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when the access size cannot start at this byte lane.
  function automatic logic lane_misaligned(input size_t size, input logic [1:0] lane);
    case (size)
      SZ_H:    lane_misaligned = lane[0];
      SZ_W:    lane_misaligned = |lane;
      default: lane_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store byte-enables/replication and load
// lane select with sign or zero extension. Shared with the fetch side.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata     = 32'h0;
    rbyte     = rword[{lane, 3'b000} +: 8];
    rhalf     = lane[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_B: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = is_unsigned ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      SZ_H: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = is_unsigned ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      SZ_W: begin
        be    = 4'b1111;
        rdata = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the core's data-memory port: one request in flight, a
// word-organised array, and a response after LATENCY wait states.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | request latched, wait-state counter running down
// RESP  | response presented until rsp_ready
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t      state, state_n;
  logic [3:0]  cnt;
  logic [31:0] a_addr;
  logic        a_we;
  size_t       a_size;
  logic        a_uns;
  logic [31:0] a_wdata;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  logic              accept;
  logic              commit;
  logic [31:0]       offset;
  logic [ADDR_W-1:0] word_idx;
  logic              in_range;
  logic              err_c;
  logic [31:0]       rword;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic [31:0]       load_data;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_valid & req_ready;

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
  assign offset   = a_addr - BASE_ADDR;
  assign word_idx = offset[ADDR_W+1:2];
  assign in_range = (offset >> (ADDR_W + 2)) == 32'd0;
  assign err_c    = (a_size == SZ_BAD) | lane_misaligned(a_size, offset[1:0]) | ~in_range;
  assign rword    = mem[word_idx];

  dmem_lane_align u_align (
    .size        (a_size),
    .lane        (offset[1:0]),
    .is_unsigned (a_uns),
    .wdata       (a_wdata),
    .rword       (rword),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .rdata       (load_data)
  );

  always_comb begin
    state_n = state;
    commit  = 1'b0;
    case (state)
      IDLE: if (accept) state_n = WAIT;
      WAIT: begin
        if (cnt == 4'd0) begin
          commit  = 1'b1;
          state_n = RESP;
        end
      end
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The accept edge only captures the request; the access always lands on a
  // later edge, so LATENCY wait states give rsp_valid LATENCY+1 edges after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      a_addr  <= 32'h0;
      a_we    <= 1'b0;
      a_size  <= SZ_B;
      a_uns   <= 1'b0;
      a_wdata <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_addr  <= req_addr;
        a_we    <= req_we;
        a_size  <= size_t'(req_size);
        a_uns   <= req_unsigned;
        a_wdata <= req_wdata;
        cnt     <= LAT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rdata_q <= (err_c | a_we) ? 32'h0 : load_data;
        err_q   <= err_c;
      end else if (state == RESP && rsp_ready) begin
        rdata_q <= 32'h0;
        err_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && a_we && !err_c) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 0) driven with
// directed and random traffic, checked by a byte-level reference model.
module tb_dmem_responder;

  localparam logic [31:0] BASE    = 32'h0001_0000;
  localparam int          DEPTH_B = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic [31:0] req_addr     [2];
  logic        req_we       [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_wdata    [2];
  logic        rsp_valid    [2];
  logic        rsp_ready    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_err      [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_responder #(.ADDR_W(10), .LATENCY(g == 0 ? 2 : 0), .BASE_ADDR(BASE)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_addr     (req_addr[g]),
      .req_we       (req_we[g]),
      .req_size     (req_size[g]),
      .req_unsigned (req_unsigned[g]),
      .req_wdata    (req_wdata[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_ready    (rsp_ready[g]),
      .rsp_rdata    (rsp_rdata[g]),
      .rsp_err      (rsp_err[g])
    );
  end

  typedef struct {
    int          k;
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mref [2][DEPTH_B];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mode [2];
  logic        held [2];
  logic        just_hs [2];
  logic [31:0] prev_rdata [2];
  logic        prev_err [2];

  task automatic fail(input string what, input logic [31:0] got, input logic [31:0] want);
    errors++;
    $display("FAIL %s: got %h want %h (cycle %0d)", what, got, want, cyc);
  endtask

  task automatic check(input string what, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) fail(what, got, want);
  endtask

  // Byte-addressed view of the memory; applies stores and returns the expected response.
  function automatic void model(input int k, input logic [31:0] addr, input logic we,
                                input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
    logic [31:0] off;
    logic [31:0] v;
    int nb;
    off   = addr - BASE;
    nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err   = (size == 2'd3) || (off % nb != 0) || (off >= DEPTH_B);
    rdata = 32'h0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < nb; i++) mref[k][off + i] = wdata[8*i +: 8];
      return;
    end
    v = 32'h0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = mref[k][off + i];
    if (nb == 1)      rdata = uns ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
    else if (nb == 2) rdata = uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    else              rdata = v;
  endfunction

  task automatic junk(input int k);
    req_addr[k]     = $urandom;
    req_we[k]       = 1'($urandom);
    req_size[k]     = 2'($urandom_range(0, 3));
    req_unsigned[k] = 1'($urandom);
    req_wdata[k]    = $urandom;
  endtask

  task automatic send(input int k, input logic [31:0] addr, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata, input bit use_exp,
                      input logic [31:0] erd, input logic eerr);
    logic [31:0] mr;
    logic        me;
    int          n;
    @(posedge clk); #1;
    req_valid[k]    = 1'b1;
    req_addr[k]     = addr;
    req_we[k]       = we;
    req_size[k]     = size;
    req_unsigned[k] = uns;
    req_wdata[k]    = wdata;
    n = 0;
    while (!req_ready[k] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready[k]) begin
      checks++;
      fail("req_ready_timeout", 32'h0, 32'h1);
      req_valid[k] = 1'b0;
      return;
    end
    model(k, addr, we, size, uns, wdata, mr, me);
    if (use_exp) sb.push_back('{k, erd, eerr, cyc + 1});
    else         sb.push_back('{k, mr, me, cyc + 1});
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    junk(k);
  endtask

  task automatic ld(input int k, input logic [31:0] addr, input logic [1:0] size, input logic uns,
                    input logic [31:0] erd, input logic eerr);
    send(k, addr, 1'b0, size, uns, 32'h0, 1'b1, erd, eerr);
  endtask

  task automatic st(input int k, input logic [31:0] addr, input logic [1:0] size,
                    input logic [31:0] wdata, input logic eerr);
    send(k, addr, 1'b1, size, 1'b0, wdata, 1'b1, 32'h0, eerr);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) fail("drain_timeout", 32'(sb.size()), 32'h0);
  endtask

  task automatic wait_valid(input int k);
    int n;
    n = 0;
    while (!rsp_valid[k] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("rsp_valid_arrives", 32'(rsp_valid[k]), 32'h1);
  endtask

  task automatic check_reset_outputs(input int k);
    check("rst_req_ready", 32'(req_ready[k]), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid[k]), 32'h0);
    check("rst_rsp_rdata", rsp_rdata[k], 32'h0);
    check("rst_rsp_err",   32'(rsp_err[k]), 32'h0);
  endtask

  task automatic directed(input int k);
    st(k, BASE + 8, 2'd2, 32'hDEADBEEF, 1'b0);
    ld(k, BASE + 8, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
    st(k, BASE + 0, 2'd2, 32'h11223344, 1'b0);
    st(k, BASE + 2, 2'd0, 32'h123456AA, 1'b0);
    ld(k, BASE + 0, 2'd2, 1'b0, 32'h11AA3344, 1'b0);
    ld(k, BASE + 2, 2'd0, 1'b0, 32'hFFFFFFAA, 1'b0);
    ld(k, BASE + 2, 2'd0, 1'b1, 32'h000000AA, 1'b0);
    st(k, BASE + 6, 2'd1, 32'hFFFF8001, 1'b0);
    ld(k, BASE + 6, 2'd1, 1'b0, 32'hFFFF8001, 1'b0);
    ld(k, BASE + 6, 2'd1, 1'b1, 32'h00008001, 1'b0);
    ld(k, BASE + 4, 2'd2, 1'b1, 32'h80010000, 1'b0);
    st(k, BASE + 4092, 2'd2, 32'hCAFEF00D, 1'b0);
    ld(k, BASE + 2, 2'd2, 1'b0, 32'h0, 1'b1);
    ld(k, BASE + 1, 2'd1, 1'b0, 32'h0, 1'b1);
    ld(k, BASE + 0, 2'd3, 1'b0, 32'h0, 1'b1);
    ld(k, BASE + 32'h1000, 2'd2, 1'b0, 32'h0, 1'b1);
    st(k, BASE + 2, 2'd2, 32'hFFFFFFFF, 1'b1);
    st(k, BASE + 3, 2'd1, 32'hFFFFFFFF, 1'b1);
    st(k, BASE + 8, 2'd3, 32'hFFFFFFFF, 1'b1);
    st(k, BASE + 32'h1000, 2'd2, 32'hFFFFFFFF, 1'b1);
    st(k, BASE - 4, 2'd2, 32'hFFFFFFFF, 1'b1);
    ld(k, BASE + 0, 2'd2, 1'b0, 32'h11AA3344, 1'b0);
    ld(k, BASE + 8, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
    ld(k, BASE + 4092, 2'd2, 1'b0, 32'hCAFEF00D, 1'b0);
    ld(k, BASE + 4095, 2'd0, 1'b0, 32'hFFFFFFCA, 1'b0);
    drain();
  endtask

  task automatic backpressure(input int k);
    int n;
    mode[k] = 2;
    ld(k, BASE + 8, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
    wait_valid(k);
    for (int i = 0; i < 5; i++) begin
      req_valid[k] = 1'b1;
      junk(k);
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid[k]), 32'h1);
      check("bp_req_ready", 32'(req_ready[k]), 32'h0);
      check("bp_rdata",     rsp_rdata[k], 32'hDEADBEEF);
      check("bp_err",       32'(rsp_err[k]), 32'h0);
      @(posedge clk); #1;
    end
    req_valid[k] = 1'b0;
    mode[k] = 0;
    n = 0;
    while (rsp_valid[k] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_release_valid", 32'(rsp_valid[k]), 32'h0);
    check("bp_idle_ready",    32'(req_ready[k]), 32'h1);
    ld(k, BASE + 0, 2'd2, 1'b0, 32'h11AA3344, 1'b0);
    ld(k, BASE + 8, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
    drain();
  endtask

  task automatic reset_tests(input int k);
    int n;
    st(k, BASE + 12, 2'd2, 32'h0, 1'b0);
    drain();
    @(posedge clk); #1;
    req_valid[k] = 1'b1; req_we[k] = 1'b1; req_size[k] = 2'd2;
    req_unsigned[k] = 1'b0; req_addr[k] = BASE + 12; req_wdata[k] = 32'h12345678;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    #1 rst = 1'b0;
    #1 check_reset_outputs(k);
    @(posedge clk); #1 rst = 1'b1;
    ld(k, BASE + 12, 2'd2, 1'b0, 32'h0, 1'b0);
    drain();

    mode[k] = 2;
    st(k, BASE + 16, 2'd2, 32'hAABBCCDD, 1'b0);
    wait_valid(k);
    #1 rst = 1'b0;
    #1 check_reset_outputs(k);
    if (sb.size() != 0) void'(sb.pop_front());
    mode[k] = 0;
    @(posedge clk); #1 rst = 1'b1;
    ld(k, BASE + 16, 2'd2, 1'b0, 32'hAABBCCDD, 1'b0);
    drain();
  endtask

  task automatic random_traffic(input int k, input int count);
    logic [31:0] off;
    int r;
    mode[k] = 1;
    for (int i = 0; i < count; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      off = 32'($urandom_range(0, 63));
      else if (r <= 8) off = 32'(4032 + $urandom_range(0, 63));
      else if ($urandom_range(0, 1) == 0) off = 32'(4096 + $urandom_range(0, 15));
      else             off = 32'h0 - 32'($urandom_range(1, 16));
      send(k, BASE + off, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
           $urandom, 1'b0, 32'h0, 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    drain();
    mode[k] = 0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      case (mode[k])
        0:       rsp_ready[k] = 1'b1;
        1:       rsp_ready[k] = ($urandom_range(0, 2) != 0);
        default: rsp_ready[k] = 1'b0;
      endcase
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < 2; k++) begin
          held[k]    = 1'b0;
          just_hs[k] = 1'b0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (rsp_valid[k]) begin
            check("req_ready_in_resp", 32'(req_ready[k]), 32'h0);
            if (!held[k]) begin
              checks++;
              if (just_hs[k]) fail("valid_after_handshake", 32'h1, 32'h0);
              checks++;
              if (sb.size() == 0) fail("unexpected_rsp", 32'(k), 32'hFFFFFFFF);
              else if (sb[0].k != k || cyc - sb[0].acc != (k == 0 ? 3 : 1))
                fail("latency", 32'(cyc - sb[0].acc), 32'(k == 0 ? 3 : 1));
            end else begin
              check("rdata_stable", rsp_rdata[k], prev_rdata[k]);
              check("err_stable",   32'(rsp_err[k]), 32'(prev_err[k]));
            end
            just_hs[k] = 1'b0;
            if (rsp_ready[k]) begin
              if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata[k], e.rdata);
                check("rsp_err",   32'(rsp_err[k]), 32'(e.err));
              end
              held[k]    = 1'b0;
              just_hs[k] = 1'b1;
            end else begin
              held[k]       = 1'b1;
              prev_rdata[k] = rsp_rdata[k];
              prev_err[k]   = rsp_err[k];
            end
          end else begin
            held[k]    = 1'b0;
            just_hs[k] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mode[k]      = 0;
      rsp_ready[k] = 1'b1;
      req_valid[k] = 1'b0;
      held[k]      = 1'b0;
      just_hs[k]   = 1'b0;
      junk(k);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) check_reset_outputs(k);
    rst = 1'b1;

    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 16; w++)     st(k, BASE + 32'(4 * w), 2'd2, 32'h0, 1'b0);
      for (int w = 1008; w < 1024; w++) st(k, BASE + 32'(4 * w), 2'd2, 32'h0, 1'b0);
      drain();
    end

    for (int k = 0; k < 2; k++) begin
      directed(k);
      backpressure(k);
      reset_tests(k);
      random_traffic(k, 200);
    end

    checks++;
    if (sb.size() != 0) fail("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
